// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter with call/return address stack
module pc_sequencer #(
    parameter int               WIDTH      = 16,
    parameter int               DEPTH      = 8,
    parameter logic [WIDTH-1:0] RESET_ADDR = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [2:0]                 op,
    input  logic [WIDTH-1:0]           newAdr,
    input  logic [WIDTH-1:0]           imm,
    output logic [WIDTH-1:0]           pc,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic                       full,
    output logic                       empty,
    output logic                       ovf_err,
    output logic                       unf_err
);
    localparam int DW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    localparam logic [2:0] OP_INC  = 3'b001;
    localparam logic [2:0] OP_JMP  = 3'b010;
    localparam logic [2:0] OP_BR   = 3'b011;
    localparam logic [2:0] OP_CALL = 3'b100;
    localparam logic [2:0] OP_RET  = 3'b101;

    logic [WIDTH-1:0] r_pc;
    logic [DW-1:0]    r_depth;
    logic             r_ovf;
    logic             r_unf;
    logic [WIDTH-1:0] r_stack [DEPTH];

    logic             w_full;
    logic             w_empty;
    logic [WIDTH-1:0] w_pc_inc;
    logic [AW-1:0]    w_push_idx;
    logic [AW-1:0]    w_top_idx;
    logic [WIDTH-1:0] w_pc_nxt;
    logic [DW-1:0]    w_depth_nxt;
    logic             w_push;
    logic             w_ovf_set;
    logic             w_unf_set;

    assign w_full     = (r_depth == DW'(DEPTH));
    assign w_empty    = (r_depth == '0);
    assign w_pc_inc   = r_pc + WIDTH'(1);
    // Push slot is only used when not full, so depth always fits the index width then.
    assign w_push_idx = AW'(r_depth);
    assign w_top_idx  = AW'(r_depth - DW'(1));

    // Next PC, stack depth and error-flag updates for the selected operation
    always_comb begin
        w_pc_nxt    = r_pc;
        w_depth_nxt = r_depth;
        w_push      = 1'b0;
        w_ovf_set   = 1'b0;
        w_unf_set   = 1'b0;
        case (op)
            OP_INC: w_pc_nxt = w_pc_inc;
            OP_JMP: w_pc_nxt = newAdr;
            OP_BR:  w_pc_nxt = r_pc + imm;
            OP_CALL: begin
                if (w_full) begin
                    w_ovf_set = 1'b1;
                end else begin
                    w_push      = 1'b1;
                    w_pc_nxt    = newAdr;
                    w_depth_nxt = r_depth + DW'(1);
                end
            end
            OP_RET: begin
                if (w_empty) begin
                    w_unf_set = 1'b1;
                end else begin
                    w_pc_nxt    = r_stack[w_top_idx];
                    w_depth_nxt = r_depth - DW'(1);
                end
            end
            default: ;
        endcase
    end

    // Architectural state; reset wins over any operation and discards the stack
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc    <= RESET_ADDR;
            r_depth <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_pc    <= w_pc_nxt;
            r_depth <= w_depth_nxt;
            r_ovf   <= r_ovf | w_ovf_set;
            r_unf   <= r_unf | w_unf_set;
        end
    end

    // Return-address storage; contents are meaningful only below depth, so no reset
    always_ff @(posedge clk) begin
        if (w_push && !reset) begin
            r_stack[w_push_idx] <= w_pc_inc;
        end
    end

    assign pc      = r_pc;
    assign depth   = r_depth;
    assign full    = w_full;
    assign empty   = w_empty;
    assign ovf_err = r_ovf;
    assign unf_err = r_unf;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - randomized self-checking bench for pc_sequencer
module tb_pc_sequencer;
    localparam int WIDTH = 16;
    localparam int DEPTH = 8;
    localparam logic [15:0] RST = 16'h0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  op;
    logic [15:0] newAdr;
    logic [15:0] imm;
    logic [15:0] pc;
    logic [3:0]  depth;
    logic        full;
    logic        empty;
    logic        ovf_err;
    logic        unf_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] m_pc;
    logic [15:0] m_stack[$];
    logic        m_ovf;
    logic        m_unf;

    pc_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_ADDR(RST)) dut (
        .clk(clk), .reset(reset), .op(op), .newAdr(newAdr), .imm(imm),
        .pc(pc), .depth(depth), .full(full), .empty(empty),
        .ovf_err(ovf_err), .unf_err(unf_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic [2:0] o, input logic [15:0] a, input logic [15:0] d, input logic r);
        if (r) begin
            m_pc = RST;
            m_stack.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            case (o)
                3'd1: m_pc = m_pc + 16'd1;
                3'd2: m_pc = a;
                3'd3: m_pc = m_pc + d;
                3'd4: begin
                    if (m_stack.size() == DEPTH) m_ovf = 1'b1;
                    else begin
                        m_stack.push_back(m_pc + 16'd1);
                        m_pc = a;
                    end
                end
                3'd5: begin
                    if (m_stack.size() == 0) m_unf = 1'b1;
                    else m_pc = m_stack.pop_back();
                end
                default: ;
            endcase
        end
    endtask

    task automatic compare_all(input string pfx);
        check({pfx, ".pc"},    32'(pc),      32'(m_pc));
        check({pfx, ".depth"}, 32'(depth),   32'(m_stack.size()));
        check({pfx, ".full"},  32'(full),    32'(m_stack.size() == DEPTH));
        check({pfx, ".empty"}, 32'(empty),   32'(m_stack.size() == 0));
        check({pfx, ".ovf"},   32'(ovf_err), 32'(m_ovf));
        check({pfx, ".unf"},   32'(unf_err), 32'(m_unf));
    endtask

    task automatic step(input string pfx, input logic [2:0] o, input logic [15:0] a,
                        input logic [15:0] d, input logic r);
        op = o; newAdr = a; imm = d; reset = r;
        model(o, a, d, r);
        @(posedge clk);
        #1;
        compare_all(pfx);
    endtask

    initial begin
        op = 3'd0; newAdr = '0; imm = '0; reset = 1'b1;
        m_pc = RST; m_ovf = 1'b0; m_unf = 1'b0;

        // reset and increment
        step("rst", 3'd0, 16'h0, 16'h0, 1'b1);
        check("rst.pc_const", 32'(pc), 32'h0);
        check("rst.empty_const", 32'(empty), 32'h1);
        for (int i = 1; i <= 3; i++) begin
            step("inc", 3'd1, 16'h0, 16'h0, 1'b0);
            check("inc.pc_const", 32'(pc), 32'(i));
        end

        // relative branch and wrap
        step("jmp10", 3'd2, 16'h0010, 16'h0, 1'b0);
        step("brneg", 3'd3, 16'h0, 16'hFFFC, 1'b0);
        check("brneg.pc_const", 32'(pc), 32'h000C);
        step("brpos", 3'd3, 16'h0, 16'h0004, 1'b0);
        check("brpos.pc_const", 32'(pc), 32'h0010);
        step("jmpff", 3'd2, 16'hFFFF, 16'h0, 1'b0);
        step("wrap", 3'd1, 16'h0, 16'h0, 1'b0);
        check("wrap.pc_const", 32'(pc), 32'h0000);
        step("brunder", 3'd3, 16'h0, 16'hFFFF, 1'b0);
        check("brunder.pc_const", 32'(pc), 32'hFFFF);

        // nested call/return
        step("jmp5", 3'd2, 16'h0005, 16'h0, 1'b0);
        step("call1", 3'd4, 16'h0100, 16'h0, 1'b0);
        step("call2", 3'd4, 16'h0200, 16'h0, 1'b0);
        check("call2.depth_const", 32'(depth), 32'd2);
        step("ret1", 3'd5, 16'h0, 16'h0, 1'b0);
        check("ret1.pc_const", 32'(pc), 32'h0101);
        step("ret2", 3'd5, 16'h0, 16'h0, 1'b0);
        check("ret2.pc_const", 32'(pc), 32'h0006);

        // fill, overflow, unwind
        for (int i = 0; i < DEPTH; i++) step("fill", 3'd4, 16'(16'h1000 + i * 16'h10), 16'h0, 1'b0);
        check("fill.full_const", 32'(full), 32'h1);
        step("ovf", 3'd4, 16'h0ABC, 16'h0, 1'b0);
        check("ovf.flag_const", 32'(ovf_err), 32'h1);
        for (int i = 0; i < DEPTH; i++) step("unwind", 3'd5, 16'h0, 16'h0, 1'b0);
        step("holdsticky", 3'd6, 16'h1234, 16'h5678, 1'b0);

        // underflow from reset
        step("rst2", 3'd1, 16'h0, 16'h0, 1'b1);
        step("unf", 3'd5, 16'h0, 16'h0, 1'b0);
        check("unf.flag_const", 32'(unf_err), 32'h1);
        step("unfinc", 3'd1, 16'h0, 16'h0, 1'b0);

        // reset during call with depth 3
        for (int i = 0; i < 3; i++) step("pre", 3'd4, 16'(16'h0300 + i), 16'h0, 1'b0);
        step("rstcall", 3'd4, 16'h0400, 16'h0, 1'b1);
        check("rstcall.depth_const", 32'(depth), 32'd0);
        step("rstret", 3'd5, 16'h0, 16'h0, 1'b0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [2:0] o;
            logic       r;
            o = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) o = 3'($urandom_range(4, 5));
            r = ($urandom_range(0, 99) == 0);
            step("rand", o, 16'($urandom), 16'($urandom), r);
        end

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end
endmodule
